mem_stage_mq: RTL
=================

Name: mem_stage_mq

Overview:
- Parametrised successor of the memory stage. Sits between EX and WB.
- Holds up to DEPTH in-order instructions, so several load/store requests can be outstanding to the dcache at once. The current stage allows only one.
- Aligns load data for XLEN 32 or 64 and serves GPR forwarding to ID from every queued entry.
- After a flush, drops the cache responses still owed for flushed entries.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
DEPTH, 4, queue entries; power of two, at least 2.
MAX_OUT, 4, limit on pending responses plus responses owed to flushed entries.
NUM_RD, 2, number of forwarding query ports.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
es_valid  in  1  EX entry valid
ms_allowin  out  1  queue can accept this cycle
es_pc  in  32  instruction PC
es_dest  in  5  destination GPR
es_gr_we  in  1  GPR write enable
es_load_op  in  1  load instruction
es_store_op  in  1  store instruction
es_mem_size  in  2  00 word, 01 byte, 10 half, 11 dword (dword only when XLEN=64)
es_sign_ext  in  1  sign-extend load data
es_result  in  XLEN  ALU result; for memory ops this is the address
es_excp  in  1  exception already raised upstream
data_data_ok  in  1  one in-order dcache response
data_rdata  in  XLEN  response data
flush  in  1  exception, ertn or refetch flush
ms_to_ws_valid  out  1  head entry ready for WB
ws_allowin  in  1  WB can accept
ws_pc  out  32  head entry PC
ws_dest  out  5  head entry destination
ws_gr_we  out  1  head entry GPR write enable
ws_excp  out  1  head entry exception flag
ws_result  out  XLEN  head entry final result
ms_pending  out  clog2(MAX_OUT+1)  count of pending responses
fwd_raddr  in  NUM_RD*5  GPR numbers queried by ID
fwd_hit  out  NUM_RD  a queued entry writes the queried GPR
fwd_stall  out  NUM_RD  the matching entry's data is not ready
fwd_data  out  NUM_RD*XLEN  forwarded value

Behaviour:
- Reset (asynchronous, active-high) clears:
  - every entry's valid, pending and done bits and its storage, to 0;
  - head, tail and count to 0;
  - drop_cnt to 0.
- Resulting output values after reset:
  - ms_allowin=1;
  - ms_to_ws_valid=0;
  - every ws_* output =0;
  - every fwd_* output =0;
  - ms_pending=0.
- Per-entry fields: valid, pending, done, pc, dest, gr_we, load, size, sign, addr_lo, result, excp.
- Push condition: es_valid && ms_allowin && !flush.
- Pushed entry state:
  - If es_excp, or neither load nor store: done=1, result=es_result.
  - Otherwise: pending=1, done=0.
- ms_allowin = (count<DEPTH) && (drop_cnt+ms_pending<MAX_OUT).
  - No pop-through: a full queue blocks a push even when a pop happens in the same cycle.
- Response routing:
  - If drop_cnt>0 when data_data_ok arrives, the response is discarded and drop_cnt decrements.
  - Otherwise the response goes to the oldest entry with pending=1: pending is cleared, done is set.
  - For a load, result = aligned data from mem_load_align.
  - For a store, result keeps es_result.
  - A response with no target and drop_cnt=0 is a protocol error; the bench asserts on it.
- Load alignment (mem_load_align):
  - Lane select uses addr_lo: byte lane = addr[log2(XLEN/8)-1:0], half lane = addr[..:1], word on XLEN=64 = addr[2].
  - Result is sign- or zero-extended per es_sign_ext.
  - Size 11 with XLEN=32 is treated as word.
- Output and pop:
  - ms_to_ws_valid = head valid && head done && !flush.
  - Pop on ms_to_ws_valid && ws_allowin.
  - A response that marks the head done becomes visible to WB the following cycle, because done is registered.
- Flush:
  - All entries are invalidated at the next edge; no push and no pop happen in the flush cycle.
  - The same-cycle response is applied first, using the routing rules above.
  - drop_cnt_next = drop_cnt + pending_after_response, where pending_after_response excludes the entry that same-cycle response just completed.
  - Entries pushed after the flush receive responses only once drop_cnt reaches 0.
- Forwarding, evaluated for each query port i:
  - Search for the youngest valid entry with gr_we && dest==raddr_i && raddr_i!=0.
  - fwd_hit = 1 if such an entry exists.
  - fwd_stall = hit && !done.
  - fwd_data = that entry's result when hit && done; otherwise 0.
- Count width: clog2(DEPTH+1). Pointers wrap modulo DEPTH.

Decomposition:
- Package mem_stage_pkg holds:
  - the mem_size encodings (MEM_W, MEM_B, MEM_H, MEM_D);
  - the queue entry struct;
  - the width helpers clog2 and lane-bit count.
- Sub-module mem_load_align: purely combinational, parametrised by XLEN; inputs rdata, addr_lo, size, sign; output aligned result.

Test Plan:
- Pipelined loads: push 3 word loads with no response yet, so ms_pending=3 → the responses return 0x11, 0x22, 0x33 in order, and WB sees the three results in push order.
- Byte load, signed: XLEN=32, addr low bits 2'b11, sign=1, rdata=0x80FF_0000 → ws_result=0xFFFF_FF80.
- Half load, unsigned: same rdata, addr 2'b10, sign=0 → ws_result=0x0000_80FF.
- Flush with responses owed: 2 loads pending, then flush while no response arrives → drop_cnt=2. Push a new load; 3 responses then arrive → only the third is written to the new load.
- Flush with a same-cycle response: flush and data_data_ok in the same cycle with 2 pending → drop_cnt=1.
- Forwarding stall: pending load to r5, then an older ALU op to r5 done with result 7 → fwd for r5 gives hit=1, stall=1. After the response 0x9 arrives → stall=0, data=0x9.
- Full queue, DEPTH=4: 4 loads queued → ms_allowin=0; the first pop re-asserts ms_allowin the next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the multi-entry memory stage:
//   - mem_size encodings carried from EX (MEM_W/MEM_B/MEM_H/MEM_D)
//   - mq_entry_t, the control/tag part of one queue entry
//   - clog2 / lane_bits width helpers usable in parameter and port declarations
package mem_stage_pkg;

  localparam logic [1:0] MEM_W = 2'b00;
  localparam logic [1:0] MEM_B = 2'b01;
  localparam logic [1:0] MEM_H = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;

  // Width-independent part of an entry. The XLEN-wide result and the
  // lane-select address bits live in parallel arrays in the top module so
  // their widths follow XLEN exactly.
  typedef struct packed {
    logic        valid;
    logic        pending;
    logic        done;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        load;
    logic [1:0]  size;
    logic        sign;
    logic        excp;
  } mq_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Address bits needed to select a byte lane inside an XLEN-wide word.
  function automatic int lane_bits(input int xlen);
    return clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
//   Combinational load-data aligner.
//   rdata   : raw XLEN-bit dcache response
//   addr_lo : low address bits selecting the lane
//   size    : MEM_B / MEM_H / MEM_W / MEM_D (MEM_D acts as MEM_W when XLEN=32)
//   sign    : 1 = sign-extend, 0 = zero-extend
//   result  : lane shifted to bit 0 and extended to XLEN
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int LB   = lane_bits(XLEN)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [LB-1:0]   addr_lo,
  input  logic [1:0]      size,
  input  logic            sign,
  output logic [XLEN-1:0] result
);

  logic [LB-1:0]   mask;
  logic [LB-1:0]   off;
  logic [XLEN-1:0] shifted;
  logic [63:0]     sh64;

  always_comb begin
    // Address bits below the access size are ignored, so the lane offset is
    // the address rounded down to the access alignment.
    case (size)
      MEM_B:   mask = '0;
      MEM_H:   mask = LB'(1);
      MEM_W:   mask = LB'(3);
      default: mask = (XLEN == 64) ? LB'(7) : LB'(3);
    endcase
    off     = addr_lo & ~mask;
    shifted = rdata >> {off, 3'b000};
    sh64    = 64'(shifted);
    case (size)
      MEM_B:   result = XLEN'({{56{sign & sh64[7]}},  sh64[7:0]});
      MEM_H:   result = XLEN'({{48{sign & sh64[15]}}, sh64[15:0]});
      MEM_W:   result = XLEN'({{32{sign & sh64[31]}}, sh64[31:0]});
      default: result = (XLEN == 64) ? XLEN'(sh64)
                                     : XLEN'({{32{sign & sh64[31]}}, sh64[31:0]});
    endcase
  end

endmodule

// File: rtl/mem_stage_mq.sv
// mem_stage_mq
//   In-order memory stage queue between EX and WB, holding up to DEPTH
//   instructions so several dcache requests can be outstanding.
//   EX side : es_valid/ms_allowin handshake, es_* instruction fields
//   dcache  : data_data_ok/data_rdata in-order responses
//   WB side : ms_to_ws_valid/ws_allowin handshake, ws_* head entry fields
//   flush   : drops all entries; responses still owed are discarded later
//   ms_pending : entries waiting on a response
//   fwd_*   : NUM_RD GPR forwarding ports searched over every queued entry
module mem_stage_mq
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4,
  parameter int NUM_RD  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         es_valid,
  output logic                         ms_allowin,
  input  logic [31:0]                  es_pc,
  input  logic [4:0]                   es_dest,
  input  logic                         es_gr_we,
  input  logic                         es_load_op,
  input  logic                         es_store_op,
  input  logic [1:0]                   es_mem_size,
  input  logic                         es_sign_ext,
  input  logic [XLEN-1:0]              es_result,
  input  logic                         es_excp,
  input  logic                         data_data_ok,
  input  logic [XLEN-1:0]              data_rdata,
  input  logic                         flush,
  output logic                         ms_to_ws_valid,
  input  logic                         ws_allowin,
  output logic [31:0]                  ws_pc,
  output logic [4:0]                   ws_dest,
  output logic                         ws_gr_we,
  output logic                         ws_excp,
  output logic [XLEN-1:0]              ws_result,
  output logic [clog2(MAX_OUT+1)-1:0]  ms_pending,
  input  logic [NUM_RD*5-1:0]          fwd_raddr,
  output logic [NUM_RD-1:0]            fwd_hit,
  output logic [NUM_RD-1:0]            fwd_stall,
  output logic [NUM_RD*XLEN-1:0]       fwd_data
);

  localparam int LB = lane_bits(XLEN);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam int OW = clog2(MAX_OUT + 1);

  mq_entry_t       ent_q [DEPTH];
  logic [XLEN-1:0] res_q [DEPTH];
  logic [LB-1:0]   alo_q [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic [OW-1:0]   drop_q;

  logic            push;
  logic            pop;
  logic            mem_op;
  logic            resp_hit;
  logic            resp_drop;
  logic            resp_apply;
  logic [PW-1:0]   resp_idx;
  logic [OW-1:0]   pend_cnt;
  logic [OW-1:0]   pend_after;
  logic [XLEN-1:0] load_data;

  // Oldest pending entry is the response target; valid entries are
  // contiguous from head, so scanning from head finds it first.
  always_comb begin
    resp_hit = 1'b0;
    resp_idx = '0;
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[head_q + PW'(i)].valid && ent_q[head_q + PW'(i)].pending) begin
        pend_cnt = pend_cnt + OW'(1);
        if (!resp_hit) begin
          resp_hit = 1'b1;
          resp_idx = head_q + PW'(i);
        end
      end
    end
  end

  // Responses owed to flushed entries are consumed before any live entry.
  assign resp_drop  = data_data_ok && (drop_q != '0);
  assign resp_apply = data_data_ok && (drop_q == '0) && resp_hit;
  assign pend_after = pend_cnt - OW'(resp_apply);
  assign ms_pending = pend_cnt;

  assign ms_allowin = (count_q < CW'(DEPTH)) &&
                      (({1'b0, drop_q} + {1'b0, pend_cnt}) < (OW+1)'(MAX_OUT));
  assign push       = es_valid && ms_allowin && !flush;
  assign mem_op     = !es_excp && (es_load_op || es_store_op);

  assign ms_to_ws_valid = ent_q[head_q].valid && ent_q[head_q].done && !flush;
  assign pop            = ms_to_ws_valid && ws_allowin;
  assign ws_pc          = ent_q[head_q].pc;
  assign ws_dest        = ent_q[head_q].dest;
  assign ws_gr_we       = ent_q[head_q].gr_we;
  assign ws_excp        = ent_q[head_q].excp;
  assign ws_result      = res_q[head_q];

  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata   (data_rdata),
    .addr_lo (alo_q[resp_idx]),
    .size    (ent_q[resp_idx].size),
    .sign    (ent_q[resp_idx].sign),
    .result  (load_data)
  );

  // Later (younger) matches overwrite earlier ones, so the youngest writer wins.
  always_comb begin
    fwd_hit   = '0;
    fwd_stall = '0;
    fwd_data  = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[head_q + PW'(i)].valid && ent_q[head_q + PW'(i)].gr_we &&
            ent_q[head_q + PW'(i)].dest == fwd_raddr[r*5 +: 5] &&
            fwd_raddr[r*5 +: 5] != 5'd0) begin
          fwd_hit[r]              = 1'b1;
          fwd_stall[r]            = !ent_q[head_q + PW'(i)].done;
          fwd_data[r*XLEN +: XLEN] = ent_q[head_q + PW'(i)].done ? res_q[head_q + PW'(i)] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        res_q[i] <= '0;
        alo_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (resp_apply) begin
        ent_q[resp_idx].pending <= 1'b0;
        ent_q[resp_idx].done    <= 1'b1;
        if (ent_q[resp_idx].load) res_q[resp_idx] <= load_data;
      end
      if (flush) begin
        // Same-cycle response is already accounted for in pend_after.
        for (int i = 0; i < DEPTH; i++) begin
          ent_q[i].valid   <= 1'b0;
          ent_q[i].pending <= 1'b0;
          ent_q[i].done    <= 1'b0;
        end
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        drop_q  <= drop_q - OW'(resp_drop) + pend_after;
      end else begin
        if (push) begin
          ent_q[tail_q] <= '{valid: 1'b1, pending: mem_op, done: !mem_op,
                             pc: es_pc, dest: es_dest, gr_we: es_gr_we,
                             load: es_load_op, size: es_mem_size,
                             sign: es_sign_ext, excp: es_excp};
          res_q[tail_q] <= es_result;
          alo_q[tail_q] <= es_result[LB-1:0];
          tail_q        <= tail_q + PW'(1);
        end
        if (pop) begin
          ent_q[head_q].valid <= 1'b0;
          head_q              <= head_q + PW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
        drop_q  <= drop_q - OW'(resp_drop);
      end
    end
  end

endmodule
